// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the serial subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only has to reach WIDTH-1.
  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - full-subtractor cell built from two half-subtractors
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1, bo1, bo2;

  half_subtractor u_hs0 (.x(x),  .y(y),   .d(d1), .bo(bo1));
  half_subtractor u_hs1 (.x(d1), .y(bin), .d(d),  .bo(bo2));

  assign bo = bo1 | bo2;
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor; SERIAL_SUBTRACTOR_ADD_EN adds port sub for add mode
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic           brw, bout_r, mode_sub, sub_in;
  logic           accept, last_bit;
  logic           cell_y, cell_d, cell_bo;

`ifdef SERIAL_SUBTRACTOR_ADD_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_bit = (state == RUN) && (cnt == LAST);

  // Add mode reuses the subtractor: a+b = a-(~b)-1, so invert the b bit, preload borrow
  // and invert the final borrow to get carry-out.
  assign cell_y = mode_sub ? b_sr[0] : ~b_sr[0];

  full_subtractor u_cell (
    .x   (a_sr[0]),
    .y   (cell_y),
    .bin (brw),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
      bout_r   <= 1'b0;
      mode_sub <= 1'b1;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      diff_sr  <= '0;
      cnt      <= '0;
      brw      <= ~sub_in;
      bout_r   <= 1'b0;
      mode_sub <= sub_in;
    end else if (state == RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
      brw     <= cell_bo;
      cnt     <= last_bit ? cnt : cnt + 1'b1;
      if (last_bit) bout_r <= mode_sub ? cell_bo : ~cell_bo;
    end
  end

  assign diff = diff_sr;
  assign bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, bout;
  logic [7:0] diff;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    .sub   (sub),
`endif
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    return s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic s, input string tag);
    logic [8:0] exp;
    int lat, busy_cnt;
    logic got;
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    exp = model(x, y, sub);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0; busy_cnt = 0; got = 1'b0;
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_diff"}, diff, exp[7:0]);
    check({tag, "_bout"}, bout, exp[8]);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
    check({tag, "_diff_hold"}, diff, exp[7:0]);
    check({tag, "_bout_hold"}, bout, exp[8]);
  endtask

  initial begin
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    logic [8:0] exp;
    int done_extra;

    // reset state
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed subtract cases
    do_op(8'h5A, 8'h23, 1'b1, "d_5a_23");
    do_op(8'h10, 8'h20, 1'b1, "d_10_20");
    do_op(8'h00, 8'h01, 1'b1, "d_00_01");
    do_op(8'hFF, 8'hFF, 1'b1, "d_ff_ff");

    // back-to-back with start held high and operands churning during RUN
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'($urandom);
      ys[i] = 8'($urandom);
    end
    @(negedge clk);
    sub = 1'b1; start = 1'b1; a = xs[0]; b = ys[0];
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      done_extra = 0;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        if (k < 9) begin
          if (done) done_extra++;
          a = 8'($urandom); b = 8'($urandom);
        end else begin
          exp = model(xs[i], ys[i], 1'b1);
          check("b2b_done", done, 1);
          check("b2b_diff", diff, exp[7:0]);
          check("b2b_bout", bout, exp[8]);
          a = xs[i+1]; b = ys[i+1];
          if (i == 2) start = 1'b0;
        end
      end
      check("b2b_no_early_done", done_extra, 0);
    end
    @(negedge clk);
    check("b2b_stop_idle", busy, 0);

    // reset mid-RUN
    repeat (2) @(negedge clk);
    a = 8'h77; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) done_extra++;
    end
    check("abort_no_done", done_extra, 0);
    do_op(8'h05, 8'h03, 1'b1, "post_reset");

`ifdef SERIAL_SUBTRACTOR_ADD_EN
    do_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_op(8'h12, 8'h34, 1'b0, "add_12_34");
`endif

    // random operands, idle gaps between operations
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom);
      y = 8'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      s = 1'($urandom);
`else
      s = 1'b1;
`endif
      do_op(x, y, s, "rand");
      exp = model(x, y, s);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check("rand_gap_diff", diff, exp[7:0]);
      check("rand_gap_bout", bout, exp[8]);
      check("rand_gap_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
